// File: rtl/vend_pkg.sv
// Shared types and default sizing for the vend dispatcher slice.
package vend_pkg;

  localparam int DEPTH_DEF       = 4;
  localparam int TIMEOUT_CYC_DEF = 16;
  localparam int CNT_W_DEF       = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ITEM_REQ,
    S_ITEM_WAIT,
    S_COIN_REQ,
    S_FAULT
  } vend_state_e;

  typedef struct packed {
    logic chg;
  } vend_evt_t;

endpackage

// File: rtl/vend_dispatcher_if.sv
// Actuator-board handshakes: item motor (req/ack/done) and coin hopper (req/ack).
interface vend_dispatcher_if;

  logic item_req;
  logic item_ack;
  logic item_done;
  logic coin_req;
  logic coin_ack;

  modport master (
    output item_req,
    output coin_req,
    input  item_ack,
    input  item_done,
    input  coin_ack
  );

  modport slave (
    input  item_req,
    input  coin_req,
    output item_ack,
    output item_done,
    output coin_ack
  );

endinterface

// File: rtl/vend_evt_fifo.sv
// Synchronous first-word-fall-through event queue; a push when full is
// accepted only alongside a pop.
module vend_evt_fifo
  import vend_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  vend_evt_t wr_data,
  input  logic      pop,
  output vend_evt_t rd_data,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  vend_evt_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; emptiness comes from
  // the pointers and count, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/vend_dispatcher.sv
// Queues vend events and sequences the item motor and coin hopper
// handshakes, with a done-timeout that parks the FSM in FAULT.
module vend_dispatcher
  import vend_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dispense,
  input  logic                    change,
  input  logic                    clear_fault,
  vend_dispatcher_if.master       act,
  output logic                    busy,
  output logic                    fault,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [CNT_W-1:0]        vend_count
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  vend_state_e      state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             chg_q;
  vend_evt_t        push_evt;
  vend_evt_t        head_evt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  assign push_evt.chg = change;
  assign fifo_pop     = (state == S_IDLE) && !fifo_empty;
  assign busy         = (state != S_IDLE) || (fifo_count != '0);

  vend_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (dispense),
    .wr_data (push_evt),
    .pop     (fifo_pop),
    .rd_data (head_evt),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // NOTE: every register here uses <= so all branches see pre-edge values;
  // a blocking update would leak into later decisions in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      act.item_req <= 1'b0;
      act.coin_req <= 1'b0;
      fault        <= 1'b0;
      overflow     <= 1'b0;
      chg_q        <= 1'b0;
      tmo_cnt      <= '0;
      vend_count   <= '0;
    end else begin
      if (dispense && fifo_full && !fifo_pop) overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            chg_q        <= head_evt.chg;
            act.item_req <= 1'b1;
            state        <= S_ITEM_REQ;
          end
        end
        S_ITEM_REQ: begin
          if (act.item_ack) begin
            act.item_req <= 1'b0;
            tmo_cnt      <= '0;
            state        <= S_ITEM_WAIT;
          end
        end
        S_ITEM_WAIT: begin
          // done is tested first so a drop on the last allowed cycle still counts
          if (act.item_done) begin
            vend_count <= vend_count + CNT_W'(1);
            if (chg_q) begin
              act.coin_req <= 1'b1;
              state        <= S_COIN_REQ;
            end else begin
              state <= S_IDLE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            fault <= 1'b1;
            state <= S_FAULT;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_COIN_REQ: begin
          if (act.coin_ack) begin
            act.coin_req <= 1'b0;
            state        <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (clear_fault) begin
            fault <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispatcher.sv
// Directed bench for vend_dispatcher: vend flows, overflow, timeout, tie, reset.
module tb_vend_dispatcher;

  logic       clk;
  logic       rst_n;
  logic       dispense;
  logic       change;
  logic       clear_fault;
  logic       busy;
  logic       fault;
  logic       overflow;
  logic [2:0] fifo_count;
  logic [7:0] vend_count;

  int errors = 0;
  int checks = 0;
  int exp_vc = 0;

  vend_dispatcher_if act_if ();

  vend_dispatcher #(.DEPTH(4), .TIMEOUT_CYC(16), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dispense    (dispense),
    .change      (change),
    .clear_fault (clear_fault),
    .act         (act_if),
    .busy        (busy),
    .fault       (fault),
    .overflow    (overflow),
    .fifo_count  (fifo_count),
    .vend_count  (vend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges; inputs set and outputs sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; dispense = 1'b0; change = 1'b0; clear_fault = 1'b0;
    act_if.item_ack = 1'b0; act_if.item_done = 1'b0; act_if.coin_ack = 1'b0;
    #1;
    check("rst_item_req", act_if.item_req, 0);
    check("rst_coin_req", act_if.coin_req, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_vend_count", vend_count, 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Dollar vend
    dispense = 1'b1; change = 1'b1;
    step(1);
    check("dol_count_after_push", fifo_count, 1);
    check("dol_req_not_yet", act_if.item_req, 0);
    dispense = 1'b0; change = 1'b0;
    step(1);
    check("dol_item_req_rise", act_if.item_req, 1);
    check("dol_count_popped", fifo_count, 0);
    step(2);
    check("dol_item_req_held", act_if.item_req, 1);
    act_if.item_ack = 1'b1;
    step(1);
    act_if.item_ack = 1'b0;
    check("dol_item_req_drop", act_if.item_req, 0);
    step(1);
    act_if.item_done = 1'b1;
    step(1);
    act_if.item_done = 1'b0;
    exp_vc++;
    check("dol_coin_req", act_if.coin_req, 1);
    check("dol_one_req", act_if.item_req, 0);
    check("dol_vend_count", vend_count, exp_vc);
    act_if.coin_ack = 1'b1;
    step(1);
    act_if.coin_ack = 1'b0;
    check("dol_coin_req_drop", act_if.coin_req, 0);
    check("dol_busy_idle", busy, 0);

    // change without dispense is ignored; stray ack in IDLE is ignored
    change = 1'b1; act_if.item_ack = 1'b1;
    step(1);
    change = 1'b0; act_if.item_ack = 1'b0;
    check("chg_only_count", fifo_count, 0);
    step(1);
    check("chg_only_busy", busy, 0);
    check("chg_only_no_req", act_if.item_req, 0);

    // Quarter vend
    dispense = 1'b1;
    step(1);
    dispense = 1'b0;
    step(1);
    check("qtr_item_req", act_if.item_req, 1);
    act_if.item_ack = 1'b1;
    step(1);
    act_if.item_ack = 1'b0;
    act_if.item_done = 1'b1;
    step(1);
    act_if.item_done = 1'b0;
    exp_vc++;
    check("qtr_vend_count", vend_count, exp_vc);
    check("qtr_no_coin", act_if.coin_req, 0);
    step(3);
    check("qtr_no_coin_later", act_if.coin_req, 0);
    check("qtr_busy", busy, 0);

    // Overflow: six back-to-back pushes with the motor stalled
    dispense = 1'b1;
    step(6);
    dispense = 1'b0;
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    check("ovf_item_req", act_if.item_req, 1);
    for (int i = 0; i < 5; i++) begin
      check("ovf_loop_req", act_if.item_req, 1);
      check("ovf_loop_count", fifo_count, 4 - i);
      act_if.item_ack = 1'b1;
      step(1);
      act_if.item_ack = 1'b0;
      act_if.item_done = 1'b1;
      step(1);
      act_if.item_done = 1'b0;
      exp_vc++;
      step(1);
    end
    check("ovf_vend_count", vend_count, exp_vc);
    check("ovf_sticky", overflow, 1);
    check("ovf_drained_busy", busy, 0);

    // Timeout: quarter event then a dollar event queued behind it
    dispense = 1'b1; change = 1'b0;
    step(1);
    change = 1'b1;
    step(1);
    dispense = 1'b0; change = 1'b0;
    check("tmo_item_req", act_if.item_req, 1);
    act_if.item_ack = 1'b1;
    step(1);
    act_if.item_ack = 1'b0;
    step(15);
    check("tmo_no_fault_yet", fault, 0);
    step(1);
    check("tmo_fault", fault, 1);
    check("tmo_no_item_req", act_if.item_req, 0);
    check("tmo_no_coin_req", act_if.coin_req, 0);
    check("tmo_vend_unchanged", vend_count, exp_vc);
    check("tmo_busy", busy, 1);
    dispense = 1'b1;
    step(1);
    dispense = 1'b0;
    check("tmo_push_in_fault", fifo_count, 2);
    check("tmo_fault_held", fault, 1);
    clear_fault = 1'b1;
    step(1);
    clear_fault = 1'b0;
    check("tmo_fault_clear", fault, 0);
    step(1);
    check("tmo_next_req", act_if.item_req, 1);
    check("tmo_next_count", fifo_count, 1);
    act_if.item_ack = 1'b1;
    step(1);
    act_if.item_ack = 1'b0;
    act_if.item_done = 1'b1;
    step(1);
    act_if.item_done = 1'b0;
    exp_vc++;
    check("tmo_next_coin_req", act_if.coin_req, 1);
    check("tmo_next_vend", vend_count, exp_vc);
    act_if.coin_ack = 1'b1;
    step(1);
    act_if.coin_ack = 1'b0;
    step(1);

    // Done arriving on the timeout cycle wins
    check("tie_item_req", act_if.item_req, 1);
    act_if.item_ack = 1'b1;
    step(1);
    act_if.item_ack = 1'b0;
    step(15);
    act_if.item_done = 1'b1;
    step(1);
    act_if.item_done = 1'b0;
    exp_vc++;
    check("tie_no_fault", fault, 0);
    check("tie_vend_count", vend_count, exp_vc);
    check("tie_busy", busy, 0);

    // Reset during ITEM_WAIT with two events queued
    dispense = 1'b1;
    step(3);
    dispense = 1'b0;
    act_if.item_ack = 1'b1;
    step(1);
    act_if.item_ack = 1'b0;
    step(2);
    check("rmid_count_before", fifo_count, 2);
    check("rmid_busy_before", busy, 1);
    rst_n = 1'b0;
    #2;
    check("rmid_item_req", act_if.item_req, 0);
    check("rmid_coin_req", act_if.coin_req, 0);
    check("rmid_overflow", overflow, 0);
    check("rmid_vend_count", vend_count, 0);
    check("rmid_fifo_count", fifo_count, 0);
    check("rmid_busy", busy, 0);
    check("rmid_fault", fault, 0);
    step(1);
    rst_n = 1'b1;
    step(2);
    check("rpost_busy", busy, 0);
    check("rpost_fifo_count", fifo_count, 0);
    check("rpost_item_req", act_if.item_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_dispatcher.md
Name: vend_dispatcher

Overview:
- Downstream consumer of the vending machine's `dispense`/`change` outputs.
- Queues vend events and drives the mechanical side through req/ack handshakes:
  - item motor (req → ack → done);
  - coin-return hopper (req → ack).
- Sits between the vending_machine core and the actuator board; reports status to the front panel.

Parameters:
- DEPTH, 4, event-queue entries (power of 2, ≥2).
- TIMEOUT_CYC, 16, max cycles from item_ack to item_done before fault.
- CNT_W, 8, width of the vend counter.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- dispense  input  1  1-cycle pulse from vending machine: vend one item.
- change  input  1  1-cycle pulse, valid only with dispense: return one quarter.
- item_req  output  1  request item motor; held until item_ack.
- item_ack  input  1  motor accepted request.
- item_done  input  1  item physically dropped.
- coin_req  output  1  request one-quarter ejection; held until coin_ack.
- coin_ack  input  1  hopper accepted.
- clear_fault  input  1  pulse, exits FAULT.
- busy  output  1  FSM not IDLE or queue non-empty.
- fault  output  1  FSM in FAULT.
- overflow  output  1  sticky; event dropped on full queue.
- fifo_count  output  $clog2(DEPTH)+1  current queue occupancy.
- vend_count  output  CNT_W  completed vends, wraps at 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0):
  - all outputs 0;
  - queue emptied, FSM=IDLE, timeout counter 0.
  - Applies mid-handshake: req dropped immediately, pending events lost.
- Push:
  - On posedge with dispense=1, write entry {chg = change}.
  - change=1 with dispense=0 is ignored, no push.
- Full queue:
  - Push without a same-cycle pop: event dropped, overflow←1 (sticky until reset).
  - Push with a same-cycle pop: accepted.
- Pop: occurs on the IDLE→ITEM_REQ transition. Empty queue: no pop, FSM stays IDLE.
- FSM states: IDLE, ITEM_REQ, ITEM_WAIT, COIN_REQ, FAULT.
  - IDLE: fifo non-empty → pop, latch chg, → ITEM_REQ.
  - ITEM_REQ: item_req=1.
    - item_ack=1 → ITEM_WAIT.
    - No timeout in this state.
  - ITEM_WAIT: item_req=0, counter increments each cycle.
    - item_done=1 → vend_count+1; then chg ? COIN_REQ : IDLE.
    - Counter reaching TIMEOUT_CYC-1 with no done → FAULT.
    - item_done on the same cycle as the timeout wins (done, not fault).
  - COIN_REQ: coin_req=1; coin_ack=1 → IDLE.
  - FAULT: no requests issued; queue still accepts pushes.
    - clear_fault=1 → IDLE.
    - The faulted event is discarded and not counted.
- Latency:
  - Push into empty queue in IDLE: item_req rises 2 cycles after the dispense edge (1 cycle write, 1 cycle pop/transition).
  - coin_req rises the cycle after item_done is sampled.
- Handshake rules:
  - Req is registered and deasserts the cycle after ack is sampled.
  - ack/done are ignored outside their state.
  - Only one req is active at any time.
- Counters:
  - vend_count wraps modulo 2^CNT_W.
  - Timeout counter clears on entry to ITEM_WAIT.
- busy = (state≠IDLE) || (fifo_count≠0).

Decomposition:
- Package vend_pkg:
  - state enum `vend_state_e`;
  - event struct `vend_evt_t` {logic chg};
  - default constants for DEPTH/TIMEOUT_CYC.
- Sub-module vend_evt_fifo: synchronous FIFO parameterised by DEPTH with push/pop/full/empty/count. Write-when-full is allowed only with a simultaneous pop.
- Top: FSM, timeout counter, vend counter.

Test Plan:
- Dollar vend: dispense=change=1 for 1 cycle; ack after 3 cycles; done after 2 more; coin_ack after 1 → item_req high 2 cycles after the pulse, then coin_req, then IDLE; vend_count=1, busy=0.
- Quarter vend: dispense=1, change=0 → item handshake completes; coin_req never asserts; vend_count=1.
- Overflow: 6 back-to-back dispense pulses, item_ack held 0 → 1 popped, fifo_count=4, overflow=1; after ack/done loop, vend_count=5 and overflow stays 1.
- Timeout: item_ack given, item_done withheld 16 cycles → fault=1 on the 16th cycle, item_req=0, vend_count unchanged; clear_fault → next queued event served.
- Done/timeout tie: item_done exactly on timeout cycle → no fault, vend_count+1.
- Reset mid-op: rst_n=0 during ITEM_WAIT with 2 queued → all outputs 0 asynchronously; after release, busy=0 and fifo_count=0.
